branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Branch prediction and resolution controller for the 5-stage core.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters. IF looks the table up; the ID-stage branch comparator outcome updates it.
- Detects mispredictions and sequences recovery: a one-cycle redirect to IF, then a flush window over younger stages.
- Keeps branch and misprediction performance counters.

Parameters:
- IDX_W, 6, BHT index width. Entries = 2^IDX_W, indexed by pc[IDX_W+1:2].
- FLUSH_CYCLES, 2, number of unstalled cycles flush stays asserted after a misprediction (1..15).
- CTR_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline stall; freezes resolve acceptance and the flush countdown.
- if_valid  input  1  IF stage holds a valid fetch.
- if_pc  input  32  fetch PC for lookup.
- pred_taken  output  1  prediction for if_pc; combinational.
- id_valid  input  1  ID stage instruction valid.
- id_is_branch  input  1  ID instruction is a conditional branch.
- id_pc  input  32  PC of the ID instruction.
- id_pred_taken  input  1  prediction carried down from IF with this instruction.
- id_actual_taken  input  1  branch comparator result.
- id_target  input  32  computed branch target.
- redirect_valid  output  1  one-cycle pulse: IF must load redirect_pc.
- redirect_pc  output  32  corrected fetch PC.
- flush  output  1  squash IF/ID younger instructions.
- branch_cnt  output  32  resolved branches.
- mispred_cnt  output  32  mispredictions.

Behaviour:
- Reset (async, rst_n=0):
  - All BHT counters = CTR_INIT; FSM = RUN.
  - redirect_valid=0, redirect_pc=0, flush=0, branch_cnt=0, mispred_cnt=0.
  - pred_taken follows the reset table, i.e. CTR_INIT[1] when if_valid=1.
  - Reset asserted mid-flush aborts the flush immediately.
- Lookup:
  - pred_taken = if_valid & bht[if_pc[IDX_W+1:2]][1].
  - Purely combinational, zero latency.
- Resolve acceptance:
  - A resolve is accepted when id_valid & id_is_branch & !stall & state==RUN.
  - Resolves arriving in FLUSH are ignored; they belong to squashed instructions.
- BHT update, on the clock edge of an accepted resolve:
  - Counter at id_pc[IDX_W+1:2] saturating-increments if id_actual_taken, else saturating-decrements.
  - 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
  - Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write).
- Counters:
  - branch_cnt += 1 per accepted resolve.
  - mispred_cnt += 1 when id_pred_taken != id_actual_taken.
  - Both wrap modulo 2^32.
- Mispredict handling, at the edge of an accepted mispredicting resolve:
  - FSM goes RUN->FLUSH; redirect_valid=1; flush=1; flush counter = FLUSH_CYCLES-1.
  - redirect_pc = id_target if id_actual_taken, else id_pc+4. Addition is 32-bit and wraps (0xFFFFFFFC+4 = 0).
- FSM states:
  - RUN: flush=0. Moves to FLUSH on mispredict; correct predictions stay in RUN with no outputs.
  - FLUSH: flush=1.
    - redirect_valid is high only in the first FLUSH cycle, regardless of stall.
    - Each cycle with stall=0 and counter!=0 decrements the counter. Counter==0 with stall=0 returns to RUN at that edge.
    - With stall=1 the counter holds and flush stays high.
    - FLUSH_CYCLES=1 gives exactly one flush cycle.
- Output registering: redirect_pc holds its last value outside redirect pulses. flush and redirect_valid are registered; no combinational path from ID inputs to them.

Test Plan:
- Reset, then if_valid=1, if_pc=0x100 -> pred_taken=0. All counters 0, flush=0, redirect_valid=0.
- Three accepted resolves at id_pc=0x100, taken, id_pred_taken matching the current prediction -> counter 01->10->11->11; pred_taken(0x100)=1 after the first. Resolve 1 (pred 0, actual taken) mispredicts; resolves 2 and 3 do not. Final branch_cnt=3, mispred_cnt=1.
- Mispredict not-taken at id_pc=0x200, id_pred_taken=1 -> next cycle redirect_valid=1, redirect_pc=0x204. flush=1 for exactly 2 cycles, then RUN.
- Mispredict taken, id_target=0x80, stall=1 for 3 cycles starting the cycle after the mispredict -> redirect_valid one cycle, redirect_pc=0x80. flush high 3+2=5 cycles. A resolve presented during flush does not change branch_cnt.
- Same-cycle lookup and update of index 5 (if_pc=id_pc=0x14, counter 10, actual not-taken) -> pred_taken=1 that cycle, 0 next cycle.
- rst_n low mid-FLUSH -> flush=0 and counters=0 immediately (asynchronously); BHT entries back to 01.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Bimodal branch predictor and mispredict recovery sequencer.
// Resolves ID-stage branches, redirects IF and flushes younger stages.
module branch_resolve_ctrl #(
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [1:0]  CTR_INIT     = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic [31:0] id_pc,
  input  logic        id_pred_taken,
  input  logic        id_actual_taken,
  input  logic [31:0] id_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);

  logic [ENTRIES-1:0][1:0] bht_q;
  logic [1:0]              ctr_q;
  logic [1:0]              ctr_d;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [3:0]  fcnt_q;
  logic [3:0]  fcnt_d;
  logic        rv_q;
  logic        rv_d;
  logic [31:0] rpc_q;
  logic [31:0] rpc_d;
  logic [31:0] br_q;
  logic [31:0] br_d;
  logic [31:0] mis_q;
  logic [31:0] mis_d;

  logic accept;
  logic mispred;
  logic unused_pc;

  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  assign lk_idx = if_pc[IDX_W+1:2];
  assign up_idx = id_pc[IDX_W+1:2];

  // Table is read from the registered copy, so a same-cycle
  // update of this index is only visible on the next cycle.
  assign pred_taken = if_valid & bht_q[lk_idx][1];

  assign accept = id_valid & id_is_branch & ~stall
                & (state_q == ST_RUN);
  assign mispred = id_pred_taken ^ id_actual_taken;

  assign ctr_q = bht_q[up_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (id_actual_taken) begin
      if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
    end else begin
      if (ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q <= {ENTRIES{CTR_INIT}};
    end else if (accept) begin
      bht_q[up_idx] <= ctr_d;
    end
  end

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (accept) begin
      br_d = br_q + 32'd1;
      if (mispred) mis_d = mis_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    case (state_q)
      ST_RUN: begin
        if (accept && mispred) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_INIT;
          rv_d    = 1'b1;
          rpc_d   = id_actual_taken ? id_target
                                    : id_pc + 32'd4;
        end
      end
      ST_FLUSH: begin
        // Stalled cycles do not consume the flush window.
        if (!stall) begin
          if (fcnt_q != 4'd0) fcnt_d = fcnt_q - 4'd1;
          else                state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= 4'd0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'd0;
      br_q    <= 32'd0;
      mis_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush          = (state_q == ST_FLUSH);
  assign branch_cnt     = br_q;
  assign mispred_cnt    = mis_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl.
// Redirects are queued when driven and checked when pulsed.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        id_valid;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        id_actual_taken;
  logic [31:0] id_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int unsigned total;
  int unsigned bad;

  logic [31:0] exp_q[$];
  logic [1:0]  m_bht [64];
  logic [31:0] e_br;
  logic [31:0] e_mis;

  branch_resolve_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .id_valid        (id_valid),
    .id_is_branch    (id_is_branch),
    .id_pc           (id_pc),
    .id_pred_taken   (id_pred_taken),
    .id_actual_taken (id_actual_taken),
    .id_target       (id_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && redirect_valid) begin
      if (exp_q.size() == 0) chk("redir_unexpected", 32'd1, 32'd0);
      else chk("redir_pc", redirect_pc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    e_br  = 32'd0;
    e_mis = 32'd0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
    chk("pred", {31'd0, pred_taken}, {31'd0, m_bht[pc[7:2]][1]});
  endtask

  task automatic resolve(input logic [31:0] pc,
                         input logic        pt,
                         input logic        at,
                         input logic [31:0] tgt);
    logic [5:0] ix;
    ix = pc[7:2];
    id_valid        = 1'b1;
    id_is_branch    = 1'b1;
    id_pc           = pc;
    id_pred_taken   = pt;
    id_actual_taken = at;
    id_target       = tgt;
    if (pt != at) exp_q.push_back(at ? tgt : pc + 32'd4);
    if (at && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'd1;
    if (!at && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'd1;
    e_br = e_br + 32'd1;
    if (pt != at) e_mis = e_mis + 32'd1;
    tick();
    id_valid     = 1'b0;
    id_is_branch = 1'b0;
    chk("branch_cnt", branch_cnt, e_br);
    chk("mispred_cnt", mispred_cnt, e_mis);
    chk("flush_after", {31'd0, flush}, {31'd0, pt != at});
  endtask

  // Holds stall for the first nstall flush cycles; optionally
  // presents a mispredicting branch that must be ignored.
  task automatic wait_flush(input int nstall,
                            input logic junk,
                            input int exp_len);
    int n;
    n = 0;
    while (flush && n < 50) begin
      n++;
      chk("rv_first", {31'd0, redirect_valid}, {31'd0, n == 1});
      stall           = (n <= nstall);
      id_valid        = junk;
      id_is_branch    = junk;
      id_pc           = 32'h0000_0040;
      id_pred_taken   = 1'b0;
      id_actual_taken = 1'b1;
      id_target       = 32'h0000_0999;
      tick();
    end
    stall        = 1'b0;
    id_valid     = 1'b0;
    id_is_branch = 1'b0;
    chk("flush_len", n, exp_len);
    chk("branch_hold", branch_cnt, e_br);
    chk("rv_low", {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n           = 1'b0;
    stall           = 1'b0;
    if_valid        = 1'b1;
    if_pc           = 32'h100;
    id_valid        = 1'b0;
    id_is_branch    = 1'b0;
    id_pc           = 32'd0;
    id_pred_taken   = 1'b0;
    id_actual_taken = 1'b0;
    id_target       = 32'd0;
    #2;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_br", branch_cnt, 32'd0);
    chk("rst_mis", mispred_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    look(32'h100);

    if_valid = 1'b0;
    #1 chk("pred_ifv0", {31'd0, pred_taken}, 32'd0);
    if_valid = 1'b1;

    resolve(32'h100, 1'b0, 1'b1, 32'h300);
    look(32'h100);
    wait_flush(0, 1'b0, 2);
    resolve(32'h100, 1'b1, 1'b1, 32'h300);
    look(32'h100);
    resolve(32'h100, 1'b1, 1'b1, 32'h300);
    look(32'h100);
    chk("cnt3_br", branch_cnt, 32'd3);
    chk("cnt3_mis", mispred_cnt, 32'd1);
    resolve(32'h100, 1'b1, 1'b0, 32'h300);
    look(32'h100);
    wait_flush(0, 1'b0, 2);

    resolve(32'h200, 1'b1, 1'b0, 32'h500);
    wait_flush(0, 1'b0, 2);
    look(32'h200);

    resolve(32'h300, 1'b0, 1'b1, 32'h80);
    wait_flush(3, 1'b1, 5);

    for (int k = 0; k < 3; k++) begin
      resolve(32'h28, 1'b0, 1'b0, 32'h0);
      look(32'h28);
    end

    resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
    wait_flush(0, 1'b0, 2);

    resolve(32'h14, 1'b0, 1'b1, 32'h700);
    wait_flush(0, 1'b0, 2);
    if_pc = 32'h14;
    #1 chk("rbw_before", {31'd0, pred_taken}, 32'd1);
    resolve(32'h14, 1'b1, 1'b0, 32'h700);
    if_pc = 32'h14;
    #1 chk("rbw_after", {31'd0, pred_taken}, 32'd0);
    wait_flush(0, 1'b0, 2);

    resolve(32'h100, 1'b0, 1'b1, 32'h900);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    model_reset();
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_br", branch_cnt, 32'd0);
    chk("arst_mis", mispred_cnt, 32'd0);
    chk("arst_rv", {31'd0, redirect_valid}, 32'd0);
    look(32'h100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    look(32'h28);
    look(32'h14);
    resolve(32'h100, 1'b0, 1'b0, 32'h0);

    tick();
    tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
